// File: rtl/iq_ctl.sv
// iq_ctl: sequencing controller for the fetch->issue instruction-queue circular buffer.
//   clock/reset_n                       : clock, synchronous active-low reset
//   fetch_valid/count/data, fetch_ready : fetch packet input (count = size-1) through a one-entry skid
//   issue_take, issue_valid, issue_data : issue grant interface (up to EXT_COUNT in-order slots)
//   flush_req                           : branch-redirect request (FLUSH then SQUASH_CYCLES of SQUASH)
//   buf_*                               : buffer insert/extract/flush ports
//   occupancy, stall_cnt, squash_cnt    : locally tracked fill level and saturating statistics
module iq_ctl #(
   parameter type T = integer,
   parameter int DEPTH = 16,
   parameter int INS_COUNT = 4,
   parameter int EXT_COUNT = 4,
   parameter int SQUASH_CYCLES = 2,
   parameter int CNT_W = 32,
   localparam int NW = $clog2(INS_COUNT),
   localparam int TW = $clog2(EXT_COUNT + 1),
   localparam int CW = $clog2(EXT_COUNT),
   localparam int OW = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             fetch_valid,
   input  logic [NW-1:0]    fetch_count,
   input  T                 fetch_data [INS_COUNT],
   output logic             fetch_ready,
   input  logic [TW-1:0]    issue_take,
   output logic [EXT_COUNT-1:0] issue_valid,
   output T                 issue_data [EXT_COUNT],
   input  logic             flush_req,
   output logic             buf_ins_enable,
   output logic [NW-1:0]    buf_new_count,
   output T                 buf_new_elements [INS_COUNT],
   output logic             buf_ext_enable,
   output logic [CW-1:0]    buf_ext_consumed,
   input  logic [EXT_COUNT-1:0] buf_ext_valid,
   input  T                 buf_out_elements [EXT_COUNT],
   output logic             buf_flush,
   output logic [OW-1:0]    occupancy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] squash_cnt
);
   typedef enum logic [1:0] {RUN, FLUSH, SQUASH} state_t;
   state_t state;
   logic skid_valid;
   logic [NW-1:0] skid_count;
   T skid_data [INS_COUNT];
   logic [3:0] sqcnt;
   logic run, from_fetch, pend_valid, can_ins, ins, found_gap;
   logic [NW-1:0] pend_n;
   logic [OW:0] need;
   logic [OW-1:0] ins_amt;
   logic [TW-1:0] k, take;
   always_comb begin
      run = reset_n && !flush_req && state == RUN;
      from_fetch = fetch_valid && !skid_valid;
      pend_valid = skid_valid || from_fetch;
      pend_n = skid_valid ? skid_count : fetch_count;
      // fill check ignores this cycle's extract: the buffer only sees freed slots next cycle
      need = (OW+1)'(occupancy) + (OW+1)'(pend_n) + (OW+1)'(1);
      can_ins = need <= (OW+1)'(DEPTH);
      ins = run && pend_valid && can_ins;
      ins_amt = ins ? OW'(pend_n) + OW'(1) : '0;
      // buffer valid flags survive its flush, so slots beyond our own count are stale
      k = '0;
      found_gap = 1'b0;
      for (int i = 0; i < EXT_COUNT; i++) begin
         if (!found_gap && buf_ext_valid[i] && OW'(i) < occupancy) k = k + TW'(1);
         else found_gap = 1'b1;
      end
      take = !run ? '0 : (issue_take < k ? issue_take : k);
      for (int i = 0; i < EXT_COUNT; i++) issue_valid[i] = run && TW'(i) < k;
      for (int i = 0; i < INS_COUNT; i++) buf_new_elements[i] = skid_valid ? skid_data[i] : fetch_data[i];
      for (int i = 0; i < EXT_COUNT; i++) issue_data[i] = buf_out_elements[i];
   end
   assign fetch_ready = state == RUN ? !skid_valid : state == SQUASH;
   assign buf_ins_enable = ins;
   assign buf_new_count = pend_n;
   assign buf_ext_enable = take != '0;
   assign buf_ext_consumed = CW'(take - TW'(1));
   assign buf_flush = reset_n && state == FLUSH;
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= RUN;
         skid_valid <= 1'b0;
         occupancy <= '0;
         sqcnt <= '0;
         stall_cnt <= '0;
         squash_cnt <= '0;
      end else if (flush_req) begin
         state <= FLUSH;
      end else begin
         case (state)
            RUN: begin
               occupancy <= occupancy + ins_amt - OW'(take);
               if (pend_valid && !can_ins) begin
                  stall_cnt <= stall_cnt + CNT_W'(~&stall_cnt);
                  if (from_fetch) begin
                     skid_valid <= 1'b1;
                     skid_count <= fetch_count;
                     skid_data <= fetch_data;
                  end
               end else if (ins && skid_valid) begin
                  skid_valid <= 1'b0;
               end
            end
            FLUSH: begin
               skid_valid <= 1'b0;
               occupancy <= '0;
               sqcnt <= 4'(SQUASH_CYCLES);
               state <= SQUASH;
            end
            default: begin
               if (fetch_valid) squash_cnt <= squash_cnt + CNT_W'(~&squash_cnt);
               sqcnt <= sqcnt - 4'd1;
               if (sqcnt == 4'd1) state <= RUN;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_iq_ctl.sv
// tb_iq_ctl: scoreboard bench for iq_ctl; stimulus queues expected buffer-port events, a monitor checks them.
module tb_iq_ctl;
   localparam int EV_INS = 0, EV_EXT = 1, EV_FLUSH = 2;
   logic clock = 1'b0;
   logic reset_n;
   logic fetch_valid;
   logic [1:0] fetch_count;
   integer fetch_data [4];
   logic fetch_ready;
   logic [2:0] issue_take;
   logic [3:0] issue_valid;
   integer issue_data [4];
   logic flush_req;
   logic buf_ins_enable;
   logic [1:0] buf_new_count;
   integer buf_new_elements [4];
   logic buf_ext_enable;
   logic [1:0] buf_ext_consumed;
   logic [3:0] buf_ext_valid;
   integer buf_out_elements [4];
   logic buf_flush;
   logic [4:0] occupancy;
   logic [31:0] stall_cnt, squash_cnt;
   typedef struct {int kind; int a; int b;} ev_t;
   ev_t q[$];
   int tests = 0, fails = 0;
   bit mon_on = 1'b0;
   iq_ctl dut (
      .clock(clock), .reset_n(reset_n), .fetch_valid(fetch_valid), .fetch_count(fetch_count),
      .fetch_data(fetch_data), .fetch_ready(fetch_ready), .issue_take(issue_take),
      .issue_valid(issue_valid), .issue_data(issue_data), .flush_req(flush_req),
      .buf_ins_enable(buf_ins_enable), .buf_new_count(buf_new_count),
      .buf_new_elements(buf_new_elements), .buf_ext_enable(buf_ext_enable),
      .buf_ext_consumed(buf_ext_consumed), .buf_ext_valid(buf_ext_valid),
      .buf_out_elements(buf_out_elements), .buf_flush(buf_flush), .occupancy(occupancy),
      .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
   );
   always #5 clock = ~clock;
   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic push(input int kind, input int a, input int b);
      q.push_back('{kind, a, b});
   endtask
   task automatic pop_chk(input string nm, input int kind, input int a, input int b);
      ev_t e;
      tests++;
      if (q.size() == 0) begin
         fails++;
         $display("FAIL %s: unexpected event a=%0d b=%0d, none expected", nm, a, b);
      end else begin
         e = q.pop_front();
         if (e.kind != kind || e.a != a || e.b != b) begin
            fails++;
            $display("FAIL %s: got kind=%0d a=%0d b=%0d expected kind=%0d a=%0d b=%0d",
                     nm, kind, a, b, e.kind, e.a, e.b);
         end
      end
   endtask
   always @(negedge clock) if (mon_on) begin
      if (buf_ins_enable) pop_chk("insert", EV_INS, int'(buf_new_count), buf_new_elements[0]);
      if (buf_ext_enable) pop_chk("extract", EV_EXT, int'(buf_ext_consumed), int'(issue_valid));
      if (buf_flush) pop_chk("flush", EV_FLUSH, 0, 0);
   end
   task automatic drv(input bit fv, input int fc, input int pid, input int take, input logic [3:0] ev, input bit fl);
      fetch_valid = fv;
      fetch_count = 2'(fc);
      for (int j = 0; j < 4; j++) fetch_data[j] = pid * 100 + j;
      issue_take = 3'(take);
      buf_ext_valid = ev;
      flush_req = fl;
   endtask
   task automatic tick;
      @(posedge clock);
      #1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "timeout");
   end
   initial begin
      for (int i = 0; i < 4; i++) buf_out_elements[i] = 10 + i;
      reset_n = 1'b0;
      drv(1, 3, 1, 4, 4'b1111, 0);
      #1;
      chk("reset_ins_en", int'(buf_ins_enable), 0);
      chk("reset_ext_en", int'(buf_ext_enable), 0);
      chk("reset_flush", int'(buf_flush), 0);
      tick;
      tick;
      chk("reset_occ", int'(occupancy), 0);
      chk("reset_ready", int'(fetch_ready), 1);
      chk("reset_stall", int'(stall_cnt), 0);
      chk("reset_squash", int'(squash_cnt), 0);
      reset_n = 1'b1;
      mon_on = 1'b1;
      chk("issue_data_pass", issue_data[2], 12);
      for (int p = 1; p <= 4; p++) begin
         push(EV_INS, 3, p * 100);
         drv(1, 3, p, 0, 4'b0000, 0);
         tick;
         chk("fill_occ", int'(occupancy), 4 * p);
      end
      drv(1, 3, 5, 0, 4'b0000, 0);
      tick;
      chk("skid_ready", int'(fetch_ready), 0);
      chk("stall_1", int'(stall_cnt), 1);
      drv(0, 0, 0, 0, 4'b0000, 0);
      tick;
      chk("stall_2", int'(stall_cnt), 2);
      push(EV_EXT, 3, 15);
      drv(0, 0, 0, 4, 4'b1111, 0);
      tick;
      chk("drain_occ", int'(occupancy), 12);
      chk("stall_3", int'(stall_cnt), 3);
      push(EV_INS, 3, 500);
      drv(0, 0, 0, 0, 4'b0000, 0);
      tick;
      chk("skid_ins_occ", int'(occupancy), 16);
      chk("skid_ins_ready", int'(fetch_ready), 1);
      chk("stall_hold", int'(stall_cnt), 3);
      for (int c = 0; c < 4; c++) begin
         push(EV_EXT, 3, 15);
         drv(0, 0, 0, 4, 4'b1111, 0);
         tick;
      end
      chk("empty_occ", int'(occupancy), 0);
      push(EV_INS, 2, 600);
      drv(1, 2, 6, 0, 4'b0000, 0);
      tick;
      chk("occ_3", int'(occupancy), 3);
      push(EV_EXT, 2, 7);
      drv(0, 0, 0, 4, 4'b1111, 0);
      tick;
      chk("limit_occ", int'(occupancy), 0);
      push(EV_INS, 3, 700);
      drv(1, 3, 7, 0, 4'b0000, 0);
      tick;
      push(EV_INS, 1, 800);
      drv(1, 1, 8, 0, 4'b0000, 0);
      tick;
      chk("occ_6", int'(occupancy), 6);
      push(EV_INS, 1, 900);
      push(EV_EXT, 2, 15);
      drv(1, 1, 9, 3, 4'b1111, 0);
      tick;
      chk("net_occ", int'(occupancy), 5);
      push(EV_INS, 3, 1000);
      drv(1, 3, 10, 0, 4'b0000, 0);
      tick;
      push(EV_INS, 3, 1100);
      drv(1, 3, 11, 0, 4'b0000, 0);
      tick;
      push(EV_INS, 2, 1200);
      drv(1, 2, 12, 0, 4'b0000, 0);
      tick;
      drv(1, 3, 13, 0, 4'b0000, 0);
      tick;
      chk("stall_4", int'(stall_cnt), 4);
      push(EV_EXT, 1, 15);
      drv(0, 0, 0, 2, 4'b1111, 0);
      tick;
      chk("occ_14", int'(occupancy), 14);
      chk("stall_5", int'(stall_cnt), 5);
      drv(0, 0, 0, 0, 4'b1111, 1);
      #1;
      chk("flushreq_ins", int'(buf_ins_enable), 0);
      tick;
      push(EV_FLUSH, 0, 0);
      drv(1, 0, 14, 4, 4'b1111, 0);
      #1;
      chk("flush_ready", int'(fetch_ready), 0);
      chk("flush_ivalid", int'(issue_valid), 0);
      tick;
      chk("flush_occ", int'(occupancy), 0);
      chk("squash_ready", int'(fetch_ready), 1);
      drv(1, 0, 15, 0, 4'b1111, 0);
      tick;
      tick;
      chk("squash_cnt_2", int'(squash_cnt), 2);
      drv(0, 0, 0, 4, 4'b1111, 0);
      #1;
      chk("stale_ivalid", int'(issue_valid), 0);
      chk("stale_ext_en", int'(buf_ext_enable), 0);
      tick;
      chk("stale_occ", int'(occupancy), 0);
      drv(0, 0, 0, 0, 4'b0000, 1);
      tick;
      push(EV_FLUSH, 0, 0);
      drv(0, 0, 0, 0, 4'b0000, 0);
      #1;
      chk("reflush_ready", int'(fetch_ready), 0);
      tick;
      drv(1, 0, 16, 0, 4'b0000, 0);
      tick;
      drv(1, 0, 17, 0, 4'b0000, 1);
      tick;
      push(EV_FLUSH, 0, 0);
      drv(1, 0, 18, 0, 4'b0000, 0);
      tick;
      tick;
      tick;
      chk("reflush_squash", int'(squash_cnt), 5);
      push(EV_INS, 0, 2000);
      drv(1, 0, 20, 0, 4'b0000, 0);
      tick;
      chk("run_after_reflush", int'(occupancy), 1);
      drv(0, 0, 0, 0, 4'b0000, 1);
      tick;
      push(EV_FLUSH, 0, 0);
      drv(0, 0, 0, 0, 4'b0000, 0);
      tick;
      reset_n = 1'b0;
      drv(1, 0, 19, 0, 4'b0000, 0);
      tick;
      reset_n = 1'b1;
      chk("midsq_occ", int'(occupancy), 0);
      chk("midsq_stall", int'(stall_cnt), 0);
      chk("midsq_squash", int'(squash_cnt), 0);
      chk("midsq_ready", int'(fetch_ready), 1);
      push(EV_INS, 1, 2100);
      drv(1, 1, 21, 0, 4'b0000, 0);
      tick;
      chk("midsq_run_occ", int'(occupancy), 2);
      drv(0, 0, 0, 0, 4'b0000, 0);
      tick;
      tick;
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
